conv_relu_maxpool: RTL and testbench
====================================

# conv_relu_maxpool

Downstream stage of the convolution layer. Consumes the two 16-bit signed feature-map streams (kernel W0 and kernel W1 results) in raster order, applies ReLU, performs 2×2 stride-2 max pooling with an internal half-row line buffer, and emits pooled pixels with a linear write address for the result memory. Runs one pass per layer `start`, signals `done` when the last pooled pixel is produced.

## Interface
- `IMG_W`, 64: conv output width in pixels; must be even (elaboration-time check).
- `IMG_H`, 64: conv output height in pixels; must be even.
- `DW`, 16: input/output data width.
- `OUT_AW`, clog2((IMG_W/2)*(IMG_H/2)) = 10: pooled address width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a new pass (restarts if already running).
- `in_valid` in 1: `in_w0`/`in_w1` carry the next raster-order pixel.
- `in_w0` in DW: signed conv result, kernel W0.
- `in_w1` in DW: signed conv result, kernel W1.
- `out_valid` out 1: pooled pixel valid.
- `out_w0` out DW: pooled result channel 0 (non-negative).
- `out_w1` out DW: pooled result channel 1 (non-negative).
- `out_addr` out OUT_AW: pooled index, row-major, 0..(IMG_W/2·IMG_H/2 − 1).
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse with final `out_valid`.

## Operation
- States: IDLE, RUN. `start` in any state → RUN, col=row=0, out_addr counter=0. Last input accepted → IDLE.
- `in_valid` ignored in IDLE. No backpressure; producer may insert gaps (in_valid low) freely.
- ReLU per channel: x<0 (MSB set) → 0, else x. Compare unsigned after ReLU; output width DW, MSB always 0.
- Per accepted pixel at (row, col):
  - even col: hold register h = relu(x).
  - odd col, even row: linebuf[col/2] = max(h, relu(x)).
  - odd col, odd row: result = max(linebuf[col/2], h, relu(x)); registered to outputs.
- Line buffer: IMG_W/2 entries × 2 channels × DW; single write/read port per channel suffices (write on even rows, read on odd rows).
- col wraps IMG_W−1 → 0 with row++; at (IMG_H−1, IMG_W−1) pass ends.
- `out_addr` increments after each `out_valid`; first output addr 0.
- `start` coincident with `in_valid`: start wins, that pixel is discarded.
- `rst` mid-pass: all state cleared immediately, line buffer contents need not be cleared (always written before read).

## Timing
- Reset values: out_valid=0, out_w0=0, out_w1=0, out_addr=0, busy=0, done=0; state IDLE.
- `busy` rises cycle after `start`.
- Latency: out_valid asserted exactly 1 cycle after the accepting edge of the odd-row, odd-col pixel; outputs held until next output (out_valid single-cycle).
- `done` and `busy` fall: done high same cycle as last out_valid; busy low from that cycle.
- Throughput: one input per cycle sustained.

## Structure
- Shared package `cnn_pkg`: DW default, relu function, unsigned max function, state enum {IDLE, RUN}.
- One sub-module natural: `pool_linebuf` (parameterized depth IMG_W/2, width 2·DW, sync write, async or sync read matched to latency).
- Top contains counters, FSM, hold registers, compare tree.

## Test plan
- IMG_W=IMG_H=4; feed w0 = 0..15 raster, w1 = −(0..15) → outputs addr0..3: w0 = 5,7,13,15; w1 = 0,0,0,0; done with addr 3.
- Mixed sign window: row0 {−3, 9}, row1 {−100, 4} → out_w0=9; all four negative (−1,−2,−3,−0x8000) → 0.
- Gapped input: in_valid toggled 1/0 randomly → identical outputs to gap-free run, out_valid only 1 cycle after each odd/odd pixel.
- `start` reasserted after 6 pixels → counters restart, first output addr 0 computed only from post-restart pixels.
- `rst` asserted mid-pass then new `start` → all outputs 0 during reset, subsequent pass matches golden model.
- Default 64×64 random signed data vs reference model: 1024 outputs, addresses 0..1023 in order, single done pulse.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN post-processing stages.
// Helpers work on a 32-bit container; callers sign- or zero-extend their DW-wide data into it.
package cnn_pkg;

  localparam int CNN_DW   = 16;
  localparam int CNN_MAXW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The argument must already be sign-extended to the container width.
  function automatic logic [CNN_MAXW-1:0] relu(input logic [CNN_MAXW-1:0] x);
    return x[CNN_MAXW-1] ? '0 : x;
  endfunction

  function automatic logic [CNN_MAXW-1:0] umax(input logic [CNN_MAXW-1:0] a,
                                               input logic [CNN_MAXW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-row line buffer for 2x2 pooling: rows of pair maxima are written on even rows and read back on odd rows.
// The read is asynchronous, so the stored pair is available in the same cycle as the odd-row pixel.
module pool_linebuf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over two raster-order feature-map streams.
// Emits one pooled pixel, with its linear result address, per odd-row / odd-column input.
module conv_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DW     = CNN_DW,
  parameter int OUT_AW = $clog2((IMG_W / 2) * (IMG_H / 2))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_w0,
  input  logic [DW-1:0]     in_w1,
  output logic              out_valid,
  output logic [DW-1:0]     out_w0,
  output logic [DW-1:0]     out_w1,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (CW > 1) ? CW - 1 : 1;

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_dim_check
    $error("conv_relu_maxpool: IMG_W and IMG_H must both be even");
  end

  function automatic logic [DW-1:0] relu_dw(input logic [DW-1:0] x);
    return DW'(relu(CNN_MAXW'(signed'(x))));
  endfunction

  function automatic logic [DW-1:0] umax_dw(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return DW'(umax(CNN_MAXW'(a), CNN_MAXW'(b)));
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [OUT_AW-1:0] r_cnt;
  logic [DW-1:0]     r_h0;
  logic [DW-1:0]     r_h1;

  logic              w_acc;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_pass_end;
  logic              w_odd_col;
  logic              w_odd_row;
  logic [DW-1:0]     w_r0;
  logic [DW-1:0]     w_r1;
  logic [DW-1:0]     w_pair0;
  logic [DW-1:0]     w_pair1;
  logic [DW-1:0]     w_max0;
  logic [DW-1:0]     w_max1;
  logic              w_lb_we;
  logic [LB_AW-1:0]  w_lb_addr;
  logic [2*DW-1:0]   w_lb_rd;

  // A start pulse wins over a coincident pixel, which is dropped.
  assign w_acc      = (r_state == RUN) && in_valid && !start;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_pass_end = w_acc && w_col_last && w_row_last;
  assign w_odd_col  = r_col[0];
  assign w_odd_row  = r_row[0];

  assign w_r0    = relu_dw(in_w0);
  assign w_r1    = relu_dw(in_w1);
  assign w_pair0 = umax_dw(r_h0, w_r0);
  assign w_pair1 = umax_dw(r_h1, w_r1);
  assign w_max0  = umax_dw(w_pair0, w_lb_rd[DW-1:0]);
  assign w_max1  = umax_dw(w_pair1, w_lb_rd[2*DW-1:DW]);

  assign w_lb_we   = w_acc && w_odd_col && !w_odd_row;
  assign w_lb_addr = LB_AW'(r_col >> 1);

  pool_linebuf #(
    .DEPTH (LB_D),
    .WIDTH (2 * DW),
    .AW    (LB_AW)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (w_lb_addr),
    .i_wdata ({w_pair1, w_pair0}),
    .o_rdata (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state == RUN);
    if (start) begin
      w_next = RUN;
    end else if (w_pass_end) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_h0      <= '0;
      r_h1      <= '0;
      out_valid <= 1'b0;
      out_w0    <= '0;
      out_w1    <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        r_col <= '0;
        r_row <= '0;
        r_cnt <= '0;
      end else if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!w_odd_col) begin
          r_h0 <= w_r0;
          r_h1 <= w_r1;
        end else if (w_odd_row) begin
          out_valid <= 1'b1;
          out_w0    <= w_max0;
          out_w1    <= w_max1;
          out_addr  <= r_cnt;
          r_cnt     <= r_cnt + 1'b1;
          done      <= w_col_last && w_row_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Self-checking bench: a 4x4 and a 64x64 instance driven with patterned and random frames,
// checked every cycle against a window-max reference model plus a few literal expectations.
module tb_conv_relu_maxpool;

  localparam int SW  = 4;
  localparam int SH  = 4;
  localparam int BW  = 64;
  localparam int BH  = 64;
  localparam int SAW = 2;
  localparam int BAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st [2];
  logic        iv [2];
  logic [15:0] a0 [2];
  logic [15:0] a1 [2];
  logic        ov [2];
  logic        bz [2];
  logic        dn [2];
  logic [15:0] o0 [2];
  logic [15:0] o1 [2];
  logic [SAW-1:0] oa_s;
  logic [BAW-1:0] oa_b;

  conv_relu_maxpool #(.IMG_W(SW), .IMG_H(SH), .DW(16), .OUT_AW(SAW)) u_small (
    .clk(clk), .rst(rst), .start(st[0]), .in_valid(iv[0]), .in_w0(a0[0]), .in_w1(a1[0]),
    .out_valid(ov[0]), .out_w0(o0[0]), .out_w1(o1[0]), .out_addr(oa_s), .busy(bz[0]), .done(dn[0])
  );

  conv_relu_maxpool #(.IMG_W(BW), .IMG_H(BH), .DW(16), .OUT_AW(BAW)) u_big (
    .clk(clk), .rst(rst), .start(st[1]), .in_valid(iv[1]), .in_w0(a0[1]), .in_w1(a1[1]),
    .out_valid(ov[1]), .out_w0(o0[1]), .out_w1(o1[1]), .out_addr(oa_b), .busy(bz[1]), .done(dn[1])
  );

  typedef struct {
    int w0;
    int w1;
    int addr;
    bit last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  bit   drv_out [2];
  bit   due [2];
  int   fr0 [2][4096];
  int   fr1 [2][4096];
  int   pix [2];
  int   oaddr [2];
  int   cap0 [2][1024];
  int   cap1 [2][1024];
  int   done_addr [2];
  int   done_cnt [2];
  int   out_cnt [2];

  function automatic int wid(int s);
    return (s == 0) ? SW : BW;
  endfunction

  function automatic int hgt(int s);
    return (s == 0) ? SH : BH;
  endfunction

  function automatic int relu(int x);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void push(int s, exp_t e);
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t pop(int s);
    if (s == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void clear_caps(int s);
    for (int i = 0; i < 1024; i++) begin
      cap0[s][i] = -1;
      cap1[s][i] = -1;
    end
    done_addr[s] = -1;
    done_cnt[s]  = 0;
    out_cnt[s]   = 0;
  endfunction

  always @(posedge clk) begin
    due[0] <= drv_out[0];
    due[1] <= drv_out[1];
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      int   adr;
      adr = (s == 0) ? int'(oa_s) : int'(oa_b);
      chk($sformatf("out_valid[%0d]", s), 32'(ov[s]), 32'(due[s]));
      if (ov[s] === 1'b1) begin
        cap0[s][adr] = int'(o0[s]);
        cap1[s][adr] = int'(o1[s]);
        out_cnt[s]++;
      end
      if (dn[s] === 1'b1) begin
        done_cnt[s]++;
        done_addr[s] = adr;
      end
      if (due[s]) begin
        if (qsize(s) == 0) begin
          total++;
          bad++;
          $display("FAIL model_queue[%0d]: got empty want entry", s);
        end else begin
          e = pop(s);
          chk($sformatf("out_w0[%0d] a%0d", s, e.addr), 32'(o0[s]), 32'(e.w0));
          chk($sformatf("out_w1[%0d] a%0d", s, e.addr), 32'(o1[s]), 32'(e.w1));
          chk($sformatf("out_addr[%0d]", s), 32'(adr), 32'(e.addr));
          chk($sformatf("done[%0d]", s), 32'(dn[s]), 32'(e.last));
          if (e.last) chk($sformatf("busy_at_done[%0d]", s), 32'(bz[s]), 32'd0);
        end
      end else begin
        chk($sformatf("done_idle[%0d]", s), 32'(dn[s]), 32'd0);
      end
    end
  end

  task automatic drive_idle(int s, bit junk);
    @(posedge clk); #1;
    st[s]      = 1'b0;
    iv[s]      = junk;
    a0[s]      = 16'($urandom);
    a1[s]      = 16'($urandom);
    drv_out[s] = 1'b0;
  endtask

  task automatic begin_pass(int s);
    @(posedge clk); #1;
    st[s]      = 1'b1;
    iv[s]      = 1'($urandom_range(0, 1));
    a0[s]      = 16'($urandom);
    a1[s]      = 16'($urandom);
    drv_out[s] = 1'b0;
    pix[s]     = 0;
    oaddr[s]   = 0;
    @(posedge clk); #1;
    st[s]      = 1'b0;
    iv[s]      = 1'b0;
    drv_out[s] = 1'b0;
    chk($sformatf("busy_after_start[%0d]", s), 32'(bz[s]), 32'd1);
  endtask

  task automatic feed(int s, logic [15:0] v0, logic [15:0] v1, int gap);
    int   w, r, c, idx, m0, m1;
    exp_t e;
    while (int'($urandom_range(0, 99)) < gap) drive_idle(s, 1'b0);
    @(posedge clk); #1;
    st[s] = 1'b0;
    iv[s] = 1'b1;
    a0[s] = v0;
    a1[s] = v1;
    w = wid(s);
    r = pix[s] / w;
    c = pix[s] % w;
    fr0[s][pix[s]] = int'($signed(v0));
    fr1[s][pix[s]] = int'($signed(v1));
    drv_out[s] = 1'b0;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      m0 = 0;
      m1 = 0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          idx = (r - 1 + dr) * w + (c - 1 + dc);
          m0  = imax(m0, relu(fr0[s][idx]));
          m1  = imax(m1, relu(fr1[s][idx]));
        end
      end
      e.w0   = m0;
      e.w1   = m1;
      e.addr = oaddr[s];
      e.last = (pix[s] == w * hgt(s) - 1);
      push(s, e);
      oaddr[s]++;
      drv_out[s] = 1'b1;
    end
    pix[s]++;
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      st[s]      = 1'b0;
      iv[s]      = 1'b1;
      a0[s]      = 16'($urandom);
      a1[s]      = 16'($urandom);
      drv_out[s] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_out_valid[%0d]", s), 32'(ov[s]), 32'd0);
      chk($sformatf("rst_out_w0[%0d]", s), 32'(o0[s]), 32'd0);
      chk($sformatf("rst_out_w1[%0d]", s), 32'(o1[s]), 32'd0);
      chk($sformatf("rst_busy[%0d]", s), 32'(bz[s]), 32'd0);
      chk($sformatf("rst_done[%0d]", s), 32'(dn[s]), 32'd0);
    end
    chk("rst_out_addr[0]", 32'(oa_s), 32'd0);
    chk("rst_out_addr[1]", 32'(oa_b), 32'd0);
    rst = 1'b0;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
  endtask

  int pat [8] = '{-3, 9, -1, -2, -100, 4, -3, -32768};

  initial begin
    for (int s = 0; s < 2; s++) begin
      st[s] = 1'b0;
      iv[s] = 1'b0;
      a0[s] = '0;
      a1[s] = '0;
      drv_out[s] = 1'b0;
      pix[s] = 0;
      oaddr[s] = 0;
      clear_caps(s);
    end
    do_reset(3);

    // Ramp frame: w0 = 0..15, w1 = -(0..15)
    clear_caps(0);
    begin_pass(0);
    for (int i = 0; i < 16; i++) feed(0, 16'(i), 16'(-i), 0);
    drive_idle(0, 1'b0);
    drive_idle(0, 1'b0);
    chk("ramp_w0_a0", 32'(cap0[0][0]), 32'd5);
    chk("ramp_w0_a1", 32'(cap0[0][1]), 32'd7);
    chk("ramp_w0_a2", 32'(cap0[0][2]), 32'd13);
    chk("ramp_w0_a3", 32'(cap0[0][3]), 32'd15);
    for (int i = 0; i < 4; i++) chk($sformatf("ramp_w1_a%0d", i), 32'(cap1[0][i]), 32'd0);
    chk("ramp_done_addr", 32'(done_addr[0]), 32'd3);
    chk("ramp_busy_after", 32'(bz[0]), 32'd0);

    // Mixed-sign and all-negative windows, gapped input, then junk pixels while idle
    clear_caps(0);
    begin_pass(0);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = (i < 8) ? 16'(pat[i]) : 16'($urandom);
      feed(0, v, 16'($urandom), 40);
    end
    repeat (5) drive_idle(0, 1'b1);
    chk("mixed_w0_a0", 32'(cap0[0][0]), 32'd9);
    chk("allneg_w0_a1", 32'(cap0[0][1]), 32'd0);
    chk("mixed_out_count", 32'(out_cnt[0]), 32'd4);

    // Restart after 6 pixels; post-restart frame w0 = 15-i, w1 = i
    begin_pass(0);
    for (int i = 0; i < 6; i++) feed(0, 16'($urandom), 16'($urandom), 20);
    clear_caps(0);
    begin_pass(0);
    for (int i = 0; i < 16; i++) feed(0, 16'(15 - i), 16'(i), 0);
    drive_idle(0, 1'b0);
    drive_idle(0, 1'b0);
    chk("restart_w0_a0", 32'(cap0[0][0]), 32'd15);
    chk("restart_w1_a0", 32'(cap1[0][0]), 32'd5);
    chk("restart_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Reset mid-pass, then a fresh random gapped pass
    begin_pass(0);
    for (int i = 0; i < 9; i++) feed(0, 16'($urandom), 16'($urandom), 10);
    do_reset(2);
    clear_caps(0);
    begin_pass(0);
    for (int i = 0; i < 16; i++) feed(0, 16'($urandom), 16'($urandom), 30);
    drive_idle(0, 1'b0);
    drive_idle(0, 1'b0);
    chk("post_rst_out_count", 32'(out_cnt[0]), 32'd4);

    // Full 64x64 random pass
    clear_caps(1);
    begin_pass(1);
    for (int i = 0; i < BW * BH; i++) feed(1, 16'($urandom), 16'($urandom), 25);
    repeat (4) drive_idle(1, 1'b0);
    chk("big_out_count", 32'(out_cnt[1]), 32'd1024);
    chk("big_done_cnt", 32'(done_cnt[1]), 32'd1);
    chk("big_done_addr", 32'(done_addr[1]), 32'd1023);
    chk("big_busy_after", 32'(bz[1]), 32'd0);

    chk("queue_empty[0]", 32'(qsize(0)), 32'd0);
    chk("queue_empty[1]", 32'(qsize(1)), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: got time limit reached, want finish before limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
